// File: rtl/fp32_uart_pkg.sv
// Shared fp32 UART definitions: FSM state encoding and default framing.
// Used by both the transmit and receive sides.
package fp32_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 444;
    localparam int DEF_NUM_BYTES    = 4;

endpackage

// File: rtl/fp32_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clear_i is high.
module fp32_uart_baud_cnt
    import fp32_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic CLK_I,
    input  logic RSTL_I,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fp32_uart_tx.sv
// fp32 UART transmitter: sends one 32-bit word as NUM_BYTES 8N1 frames,
// LSB byte first, each frame followed by an extra high gap bit.
module fp32_uart_tx
    import fp32_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_BYTES    = DEF_NUM_BYTES
) (
    input  logic        CLK_I,
    input  logic        RSTL_I,
    input  logic        TX_VALID_I,
    input  logic [31:0] TX_DATA_I,
    output logic        TX_READY_O,
    output logic        UART_TX_O,
    output logic        TX_DONE_O
);

    localparam int BW = $clog2(NUM_BYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    uart_state_e   state_q;
    logic [31:0]   shift_q;
    logic [2:0]    bit_q;
    logic [BW-1:0] byte_q;
    logic          tx_q;
    logic          ready_q;
    logic          done_q;

    logic          bit_end;
    logic          handshake;
    logic          baud_clear;

    assign handshake  = TX_VALID_I && ready_q;
    assign baud_clear = (state_q == ST_IDLE);

    assign TX_READY_O = ready_q;
    assign UART_TX_O  = tx_q;
    assign TX_DONE_O  = done_q;

    fp32_uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK_I     (CLK_I),
        .RSTL_I    (RSTL_I),
        .clear_i   (baud_clear),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        state_q <= ST_START;
                        shift_q <= TX_DATA_I;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                // Shifting once per data bit leaves the next byte at [7:0].
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[31:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (bit_end) begin
                        byte_q <= byte_q + 1'b1;
                        if (byte_q == LAST_BYTE) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp32_uart_tx.md
FP32_UART_TX -- requirements
Module: fp32_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 444: clock cycles per UART bit period.
REQ-002 SHALL provide parameter NUM_BYTES, default 4: bytes per transfer (one fp32 word).
REQ-003 SHALL have port CLK_I, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTL_I, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port TX_VALID_I, input, 1 bit: TX_DATA_I holds a word to send.
REQ-006 SHALL have port TX_DATA_I, input, 32 bits: fp32 word; byte 0 = [7:0].
REQ-007 SHALL have port TX_READY_O, output, 1 bit: block idle and accepting a word.
REQ-008 SHALL have port UART_TX_O, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port TX_DONE_O, output, 1 bit: one-cycle pulse when a transfer completes.

Function
REQ-010 Handshake SHALL be a transfer on a rising edge where TX_VALID_I=1 and TX_READY_O=1; TX_DATA_I is captured into an internal 32-bit shift register on that edge.
REQ-011 TX_READY_O SHALL be 1 only in IDLE; it drops on the handshake edge.
REQ-012 TX_VALID_I and TX_DATA_I SHALL be ignored while TX_READY_O=0; changes to them do not affect the word in flight.
REQ-013 States SHALL be IDLE, START, DATA, STOP, GAP.
REQ-014 IDLE -> START on handshake; UART_TX_O goes 0 in the first cycle after the handshake edge.
REQ-015 START SHALL hold UART_TX_O=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA SHALL drive 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-017 STOP SHALL hold UART_TX_O=1 for CLKS_PER_BIT cycles, then go to GAP.
REQ-018 GAP SHALL hold UART_TX_O=1 for CLKS_PER_BIT cycles, giving the far-end receiver a second high period before the next start.
REQ-019 At GAP end, if bytes sent < NUM_BYTES, SHALL go to START for the next byte; otherwise SHALL go to IDLE.
REQ-020 Bytes SHALL be sent in ascending order: [7:0], [15:8], [23:16], [31:24].
REQ-021 One byte frame SHALL be 11*CLKS_PER_BIT cycles; with default parameters a full transfer SHALL be 4*11*444 = 19536 cycles from the first start-bit cycle to the return to IDLE.
REQ-022 TX_DONE_O SHALL be 1 for exactly the first cycle back in IDLE, coincident with TX_READY_O returning to 1.
REQ-023 A handshake in that same cycle SHALL be accepted; that back-to-back case inserts exactly one idle-high cycle between frames.
REQ-024 The bit counter SHALL be 3 bits and wrap 7->0; the byte counter SHALL be $clog2(NUM_BYTES+1) bits.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and clear on every bit boundary and on the handshake.
REQ-026 UART_TX_O SHALL be driven from a flop; it never glitches.

Reset
REQ-027 While RSTL_I=0, outputs SHALL be: UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0, state=IDLE, and all counters and the shift register = 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately; no TX_DONE_O pulse occurs, and the partial frame is not resumed after reset.

Structure
REQ-029 Package fp32_uart_pkg SHALL hold the state enum, the default CLKS_PER_BIT (444) and the default NUM_BYTES (4); it is shared with the receive side.
REQ-030 The baud counter SHALL be sub-module fp32_uart_baud_cnt, with inputs CLK_I, RSTL_I and clear, and a bit_end tick output.

Verification
REQ-031 Reset: hold RSTL_I=0 for 10 cycles -> UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0 throughout.
REQ-032 Send 32'h3F800000 -> a bench UART model sampling mid-bit decodes bytes 0x00, 0x00, 0x80, 0x3F; the start bit is low for exactly 444 cycles; TX_DONE_O pulses once, 19536 cycles after the first start-bit cycle.
REQ-033 Hold TX_VALID_I=1 and change TX_DATA_I to 32'hDEADBEEF mid-transfer -> the line still carries the original word; 32'hDEADBEEF is accepted only at the next READY.
REQ-034 Back-to-back: TX_VALID_I held at 1 with 32'hC0490FDB, then 32'h40490FDB -> exactly 1 idle-high cycle between the final GAP and the next start bit; both words decode correctly.
REQ-035 Pulse RSTL_I low during DATA of byte 2 -> UART_TX_O=1 within the same cycle, no TX_DONE_O, TX_READY_O=1; a following send of 32'h00000001 decodes as 0x01, 0x00, 0x00, 0x00.
REQ-036 Parameter override CLKS_PER_BIT=16 with 32'hFFFFFFFF -> every bit is 16 cycles, 4 frames of 0xFF, transfer length 704 cycles.
